// File: rtl/stack_if.sv
// ---------------------------------------------------------------------------
// stack_if
// PC/stack handshake bundle between the program counter / instruction
// sequencer (master) and the stack responder (slave, stack_unit).
//
// Master -> slave:
//   enable_stack   qualifies push_1_stack / push_2_stack
//   push_1_stack   push stack_in (PC low byte)
//   push_2_stack   push stack_in (PC high byte)
//   stack_in[7:0]  byte for PC pushes
//   ret_req        start two-byte return pop (RET/RETI), one-cycle pulse
//   data_push      PUSH instruction, pushes data_in
//   data_in[7:0]   byte for data_push
//   data_pop       POP instruction, pops to data_out
//   sp_we          load SP from sp_wdata
//   sp_wdata[7:0]  new SP value
// Slave -> master:
//   pop_1_stack    strobe, stack_out holds return high byte
//   pop_2_stack    strobe, stack_out holds return low byte
//   stack_out[7:0] popped byte for the PC
//   data_out[7:0]  popped byte for POP
//   data_valid     strobe with data_out
//   busy           return sequence in progress
//   sp[7:0]        current stack pointer
//   stack_err      sticky guard / protocol error
// ---------------------------------------------------------------------------
interface stack_if;
    logic       enable_stack;
    logic       push_1_stack;
    logic       push_2_stack;
    logic [7:0] stack_in;
    logic       ret_req;
    logic       data_push;
    logic [7:0] data_in;
    logic       data_pop;
    logic       sp_we;
    logic [7:0] sp_wdata;

    logic       pop_1_stack;
    logic       pop_2_stack;
    logic [7:0] stack_out;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic [7:0] sp;
    logic       stack_err;

    modport master (
        output enable_stack, push_1_stack, push_2_stack, stack_in,
        output ret_req, data_push, data_in, data_pop, sp_we, sp_wdata,
        input  pop_1_stack, pop_2_stack, stack_out, data_out,
        input  data_valid, busy, sp, stack_err
    );

    modport slave (
        input  enable_stack, push_1_stack, push_2_stack, stack_in,
        input  ret_req, data_push, data_in, data_pop, sp_we, sp_wdata,
        output pop_1_stack, pop_2_stack, stack_out, data_out,
        output data_valid, busy, sp, stack_err
    );
endinterface

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Responder side of the 8051 PC/stack interface. Owns the stack pointer and
// the stack storage; accepts PC return-address pushes, performs the two-byte
// RET/RETI pop (high byte then low byte), and services PUSH/POP instructions
// and direct SP loads.
//
// Ports:
//   clk   system clock, all state changes on posedge
//   rst   synchronous, active-high reset
//   bus   stack_if.slave (see rtl/stack_if.sv for the signal list)
//
// Parameters:
//   DEPTH     stack storage bytes, power of two, max 256 (index = sp mod DEPTH)
//   SP_RESET  SP value after reset
//
// Build option:
//   STACK_GUARD_EN  when defined, a push at sp==DEPTH-1 and a pop at sp==0 are
//                   blocked and set stack_err. Without it SP simply wraps and
//                   stack_err flags only a simultaneous push_1/push_2.
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int         DEPTH    = 128,
    parameter logic [7:0] SP_RESET = 8'h07
) (
    input  logic   clk,
    input  logic   rst,
    stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Return FSM: each state names the cycle in which its strobe is visible.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_POP_HI = 2'd1;
    localparam logic [1:0] ST_POP_LO = 2'd2;

    // Operation selected for this cycle after priority resolution.
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DPOP = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_SPWE = 3'd4;

    logic [1:0] state;
    logic [7:0] sp_q;
    logic [7:0] sp_inc;
    logic [7:0] sp_dec;
    logic [7:0] mem [DEPTH];

    logic       pop_1_q;
    logic       pop_2_q;
    logic       data_valid_q;
    logic [7:0] stack_out_q;
    logic [7:0] data_out_q;
    logic       stack_err_q;

    logic [2:0] op;
    logic [7:0] push_byte;
    logic       dual_push;
    logic       push_block;
    logic       pop_block;
    logic       pop_now;
    logic       mem_we;
    logic [7:0] pop_byte;

    assign sp_inc = sp_q + 8'd1;
    assign sp_dec = sp_q - 8'd1;

    // Priority decode. Only one operation per cycle; anything lower is dropped.
    // The return FSM outranks every request, so nothing is decoded while busy.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        op        = OP_NONE;
        push_byte = 8'h00;
        dual_push = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.enable_stack && bus.push_1_stack) begin
                op        = OP_PUSH;
                push_byte = bus.stack_in;
                dual_push = bus.push_2_stack;
            end else if (bus.enable_stack && bus.push_2_stack) begin
                op        = OP_PUSH;
                push_byte = bus.stack_in;
            end else if (bus.data_push) begin
                op        = OP_PUSH;
                push_byte = bus.data_in;
            end else if (bus.data_pop) begin
                op = OP_DPOP;
            end else if (bus.ret_req) begin
                op = OP_RET;
            end else if (bus.sp_we) begin
                op = OP_SPWE;
            end
        end
    end

`ifdef STACK_GUARD_EN
    localparam logic [7:0] SP_TOP = 8'(DEPTH - 1);
    assign push_block = (sp_q == SP_TOP);
    assign pop_block  = (sp_q == 8'h00);
`else
    assign push_block = 1'b0;
    assign pop_block  = 1'b0;
`endif

    // The return high byte is popped on the ret_req edge, the low byte on the
    // following edge, so both strobes land on the two cycles after ret_req.
    assign pop_now  = (op == OP_DPOP) || (op == OP_RET) || (state == ST_POP_HI);
    assign pop_byte = pop_block ? 8'h00 : mem[sp_q[AW-1:0]];
    assign mem_we   = !rst && (op == OP_PUSH) && !push_block;

    // NOTE: the stack RAM has no reset; its contents survive rst like the
    // 8051 internal RAM, which also lets it map onto a plain memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[sp_inc[AW-1:0]] <= push_byte;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            sp_q         <= SP_RESET;
            pop_1_q      <= 1'b0;
            pop_2_q      <= 1'b0;
            data_valid_q <= 1'b0;
            stack_out_q  <= 8'h00;
            data_out_q   <= 8'h00;
            stack_err_q  <= 1'b0;
        end else begin
            pop_1_q      <= (op == OP_RET);
            pop_2_q      <= (state == ST_POP_HI);
            data_valid_q <= (op == OP_DPOP);

            if ((op == OP_RET) || (state == ST_POP_HI)) begin
                stack_out_q <= pop_byte;
            end
            if (op == OP_DPOP) begin
                data_out_q <= pop_byte;
            end

            if ((op == OP_PUSH) && !push_block) begin
                sp_q <= sp_inc;
            end else if (pop_now && !pop_block) begin
                sp_q <= sp_dec;
            end else if (op == OP_SPWE) begin
                sp_q <= bus.sp_wdata;
            end

            if (dual_push || ((op == OP_PUSH) && push_block) || (pop_now && pop_block)) begin
                stack_err_q <= 1'b1;
            end

            case (state)
                ST_IDLE:   state <= (op == OP_RET) ? ST_POP_HI : ST_IDLE;
                ST_POP_HI: state <= ST_POP_LO;
                ST_POP_LO: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pop_1_stack = pop_1_q;
    assign bus.pop_2_stack = pop_2_q;
    assign bus.stack_out   = stack_out_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.sp          = sp_q;
    assign bus.stack_err   = stack_err_q;
endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit (DEPTH=128, SP_RESET=8'h07). A table of
// one-cycle vectors carries the inputs and the hand-computed outputs expected
// right after the edge that consumes them; reset, mid-return reset and the
// boundary/wrap behaviour are written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_stack_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    stack_if bus ();

    stack_unit #(
        .DEPTH    (128),
        .SP_RESET (8'h07)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic       p1;
        logic       p2;
        logic [7:0] sin;
        logic       ret;
        logic       dpush;
        logic [7:0] din;
        logic       dpop;
        logic       spwe;
        logic [7:0] spwd;
        logic [7:0] e_sp;
        logic       e_p1;
        logic       e_p2;
        logic [7:0] e_so;
        logic       e_dv;
        logic [7:0] e_do;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.enable_stack = t.en;
        bus.push_1_stack = t.p1;
        bus.push_2_stack = t.p2;
        bus.stack_in     = t.sin;
        bus.ret_req      = t.ret;
        bus.data_push    = t.dpush;
        bus.data_in      = t.din;
        bus.data_pop     = t.dpop;
        bus.sp_we        = t.spwe;
        bus.sp_wdata     = t.spwd;
    endtask

    task automatic clear_inputs();
        bus.enable_stack = 1'b0;
        bus.push_1_stack = 1'b0;
        bus.push_2_stack = 1'b0;
        bus.stack_in     = 8'h00;
        bus.ret_req      = 1'b0;
        bus.data_push    = 1'b0;
        bus.data_in      = 8'h00;
        bus.data_pop     = 1'b0;
        bus.sp_we        = 1'b0;
        bus.sp_wdata     = 8'h00;
    endtask

    task automatic check_all(input string n, input logic [7:0] sp, input logic p1, input logic p2,
                             input logic [7:0] so, input logic dv, input logic [7:0] dout,
                             input logic busy, input logic err);
        check({n, " sp"},         bus.sp,          sp);
        check({n, " pop_1"},      bus.pop_1_stack, p1);
        check({n, " pop_2"},      bus.pop_2_stack, p2);
        check({n, " stack_out"},  bus.stack_out,   so);
        check({n, " data_valid"}, bus.data_valid,  dv);
        check({n, " data_out"},   bus.data_out,    dout);
        check({n, " busy"},       bus.busy,        busy);
        check({n, " stack_err"},  bus.stack_err,   err);
    endtask

    // Drive one vector for exactly one posedge, then compare just after it.
    task automatic run_vec(input vec_t t);
        @(negedge clk);
        drive(t);
        @(posedge clk);
        #1;
        check_all(t.name, t.e_sp, t.e_p1, t.e_p2, t.e_so, t.e_dv, t.e_do, t.e_busy, t.e_err);
    endtask

    task automatic op_vec(input string n, input logic dpush, input logic [7:0] din, input logic dpop,
                          input logic spwe, input logic [7:0] spwd, input logic ret,
                          input logic [7:0] e_sp, input logic e_p1, input logic e_p2,
                          input logic [7:0] e_so, input logic e_dv, input logic [7:0] e_do,
                          input logic e_busy, input logic e_err);
        run_vec(vec_t'{n, 1'b0, 1'b0, 1'b0, 8'h00, ret, dpush, din, dpop, spwe, spwd,
                       e_sp, e_p1, e_p2, e_so, e_dv, e_do, e_busy, e_err});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();

        //              name            en    p1    p2    sin    ret   dpush din    dpop  spwe  spwd    sp     p1    p2    so     dv    do     busy  err
        vecs.push_back(vec_t'{"push1_lo",   1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"push2_hi",   1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"ret_hi",     1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back(vec_t'{"push_busy",  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back(vec_t'{"ret_done",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"dpush_aa",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"dpop_aa",    1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 8'h34, 1'b1, 8'hAA, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"idle",       1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 8'h34, 1'b0, 8'hAA, 1'b0, 1'b0});
        vecs.push_back(vec_t'{"dual_push",  1'b1, 1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 8'h34, 1'b0, 8'hAA, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"push_off",   1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 8'h34, 1'b0, 8'hAA, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"dpop_56",    1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 8'h34, 1'b1, 8'h56, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"prio_push2", 1'b1, 1'b0, 1'b1, 8'h9A, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h40, 8'h08, 1'b0, 1'b0, 8'h34, 1'b0, 8'h56, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"prio_dpop",  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h07, 1'b0, 1'b0, 8'h34, 1'b1, 8'h9A, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"prio_dpush", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 8'h20, 8'h08, 1'b0, 1'b0, 8'h34, 1'b0, 8'h9A, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"dpush_cc",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 8'h34, 1'b0, 8'h9A, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"prio_ret",   1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h30, 8'h08, 1'b1, 1'b0, 8'hCC, 1'b0, 8'h9A, 1'b1, 1'b1});
        vecs.push_back(vec_t'{"busy_drop",  1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h50, 8'h07, 1'b0, 1'b1, 8'hBB, 1'b0, 8'h9A, 1'b1, 1'b1});
        vecs.push_back(vec_t'{"busy_end",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 8'h07, 1'b0, 1'b0, 8'hBB, 1'b0, 8'h9A, 1'b0, 1'b1});
        vecs.push_back(vec_t'{"sp_write",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 8'h20, 1'b0, 1'b0, 8'hBB, 1'b0, 8'h9A, 1'b0, 1'b1});

        // Reset, then five idle cycles with everything at its reset value.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("reset_idle%0d", i), 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a return: no low-byte strobe may follow.
        op_vec("mid_push", 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'h21, 1'b0, 1'b0, 8'hBB, 1'b0, 8'h9A, 1'b0, 1'b1);
        op_vec("mid_ret",  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0, 8'h11, 1'b0, 8'h9A, 1'b1, 1'b1);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("mid_rst", 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("mid_after", 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Top-of-storage push and SP wrap / guard behaviour.
        op_vec("top_spwe", 1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef STACK_GUARD_EN
        op_vec("top_push",  1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        op_vec("bot_spwe",  1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        op_vec("bot_pop",   1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
        op_vec("bot_ret1",  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        op_vec("bot_ret2",  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        op_vec("bot_done",  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
`else
        op_vec("top_push",  1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op_vec("idx0_pop",  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
        op_vec("ff_spwe",   1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);
        op_vec("wrap_push", 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);
        op_vec("wrap_pop",  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0);
        run_vec(vec_t'{"wrap_dual", 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,
                       8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h66, 1'b0, 1'b1});
        op_vec("dual_pop",  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1);
`endif

        @(negedge clk);
        clear_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Responder side of the PC/stack interface: owns the 8051 stack pointer (SP) and the stack storage.
- Accepts the two-byte return-address push issued by the program counter on interrupt entry (low byte first, then high byte).
- On RET/RETI, pops the two bytes back in reverse order, driving pop_1_stack (high byte) then pop_2_stack (low byte) with stack_out.
- Also services single-byte PUSH/POP instructions and direct SP writes (MOV SP,#d).

Parameters:
- DEPTH, 128, stack storage bytes; addresses 0..DEPTH-1 (8051 internal RAM); power of two, max 256.
- SP_RESET, 8'h07, SP value after reset.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- enable_stack  input  1  qualifies push_1_stack/push_2_stack; pushes ignored when 0
- push_1_stack  input  1  push stack_in (PC low byte); one push per cycle asserted
- push_2_stack  input  1  push stack_in (PC high byte); one push per cycle asserted
- stack_in  input  8  byte to push for PC pushes
- ret_req  input  1  start two-byte return pop (RET/RETI), single-cycle pulse
- data_push  input  1  PUSH instruction: push data_in
- data_in  input  8  byte for data_push
- data_pop  input  1  POP instruction: pop to data_out
- sp_we  input  1  load SP from sp_wdata
- sp_wdata  input  8  new SP value
- pop_1_stack  output  1  one-cycle strobe; stack_out holds return high byte
- pop_2_stack  output  1  one-cycle strobe; stack_out holds return low byte
- stack_out  output  8  popped byte for the PC, registered
- data_out  output  8  popped byte for POP, registered
- data_valid  output  1  one-cycle strobe with data_out
- busy  output  1  return sequence in progress
- sp  output  8  current stack pointer
- stack_err  output  1  sticky guard error (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): sp=SP_RESET; state=IDLE; pop_1_stack=0, pop_2_stack=0, data_valid=0, stack_out=0, data_out=0, busy=0, stack_err=0. Memory contents are not cleared. Reset mid-sequence aborts it; no further pop strobes.
- Push (any kind): pre-increment. sp<=sp+1 and mem[(sp+1) mod DEPTH]<=byte, same edge. Latency 1 cycle.
- Pop: post-decrement. Output register<=mem[sp mod DEPTH], sp<=sp-1, same edge. Strobe valid in the cycle after the request.
- SP arithmetic: 8-bit, wraps 8'hFF->8'h00 and 8'h00->8'hFF. Memory index is sp[log2(DEPTH)-1:0].
- Priority per cycle, highest first: rst, active return FSM, push_1_stack, push_2_stack, data_push, data_pop, ret_req, sp_we. Exactly one operation per cycle; lower-priority requests in that cycle are dropped, not queued.
- push_1_stack and push_2_stack together: push_1 executes, push_2 is dropped, and stack_err is set (sticky) regardless of the macro.
- Return FSM states:
  - IDLE -> POP_HI on ret_req when no higher-priority request is present; busy=1 from the next cycle.
  - POP_HI: stack_out<=mem[sp], pop_1_stack=1 for one cycle, sp<=sp-1 -> POP_LO.
  - POP_LO: stack_out<=mem[sp], pop_2_stack=1 for one cycle, sp<=sp-1 -> IDLE; busy=0 next cycle.
  - Pop strobes occur on two consecutive cycles, starting 1 cycle after ret_req.
  - While busy, all push, pop, ret_req and sp_we requests are ignored.
- data_valid and the pop strobes are never asserted in the same cycle.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined:
  - A push with sp==DEPTH-1 is blocked (sp and memory unchanged) and sets stack_err.
  - A pop with sp==0 is blocked and sets stack_err; the strobe still fires with output 8'h00.
  - On a blocked return, the FSM still completes both strobes.
  - stack_err clears only on rst.
- Undefined: no bounds checks; SP and index wrap per the arithmetic rules; stack_err is set only by the simultaneous-push condition.

Test Plan:
- Reset then idle 5 cycles -> sp=8'h07, all strobes 0, busy=0, stack_err=0.
- enable_stack=1; push_1 with stack_in=8'h34, next cycle push_2 with 8'h12 -> sp=8'h09, mem[8]=8'h34, mem[9]=8'h12.
- ret_req pulse after the previous test -> cycle+1: pop_1_stack=1, stack_out=8'h12; cycle+2: pop_2_stack=1, stack_out=8'h34; sp=8'h07; busy high for exactly 2 cycles.
- data_push 8'hAA during busy -> ignored, sp unchanged; data_push 8'hAA then data_pop when idle -> data_valid=1, data_out=8'hAA, sp back to its prior value.
- push_1_stack and push_2_stack in the same cycle -> only one push, sp+1, stack_err=1 until rst.
- STACK_GUARD_EN defined: sp_we with 8'h7F, then data_push -> sp stays 8'h7F, stack_err=1. Undefined: same stimulus -> sp=8'h80, byte written at index 0.
